// File: rtl/gemm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gemm_seq_pkg
// Brief    : Shared state encoding and defaults for the tile-GEMM sequencer
// Revision : 1.0
// ============================================================================
package gemm_seq_pkg;

    localparam int c_row_w             = 16;
    localparam int c_result_skip_def   = 1;
    localparam int c_drain_timeout_def = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        START  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : seq_skid_reg
// Brief    : One-entry holding register between the act buffer and the array
// Revision : 1.0
// ============================================================================
module seq_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Fresh read data passes straight through; it is only parked when refused.
    assign out_valid = r_full | in_valid;
    assign out_data  = r_full ? r_data : (in_valid ? in_data : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (out_valid && !out_ready) begin
            r_full <= 1'b1;
            r_data <= out_data;
        end else begin
            r_full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gemm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gemm_tile_sequencer
// Brief    : Weight load, start, act streaming and result write-back for one tile
// Revision : 1.0
// ============================================================================
module gemm_tile_sequencer
    import gemm_seq_pkg::*;
#(
    parameter int ARRAY_SIZE    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int ACC_WIDTH     = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int RESULT_SKIP   = c_result_skip_def,
    parameter int DRAIN_TIMEOUT = c_drain_timeout_def
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [15:0]                      cmd_m_rows,
    input  logic [ADDR_WIDTH-1:0]            cmd_w_base,
    input  logic [ADDR_WIDTH-1:0]            cmd_a_base,
    input  logic [ADDR_WIDTH-1:0]            cmd_c_base,
    output logic                             wb_rd_en,
    output logic [ADDR_WIDTH-1:0]            wb_rd_addr,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wb_rd_data,
    output logic                             ab_rd_en,
    output logic [ADDR_WIDTH-1:0]            ab_rd_addr,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] ab_rd_data,
    output logic                             cb_wr_en,
    output logic [ADDR_WIDTH-1:0]            cb_wr_addr,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  cb_wr_data,
    output logic                             sa_start,
    output logic                             sa_clear_acc,
    output logic [15:0]                      sa_cfg_k_tiles,
    output logic                             sa_weight_load_en,
    output logic [$clog2(ARRAY_SIZE)-1:0]    sa_weight_load_col,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] sa_weight_load_data,
    output logic                             sa_act_valid,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] sa_act_data,
    input  logic                             sa_act_ready,
    input  logic                             sa_result_valid,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  sa_result_data,
    output logic                             sa_result_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int c_col_w = $clog2(ARRAY_SIZE);
    localparam int c_vec_w = ARRAY_SIZE * DATA_WIDTH;

    seq_state_t              r_state, w_next;
    logic [c_row_w-1:0]      r_m_rows;
    logic [ADDR_WIDTH-1:0]   r_w_base, r_a_base, r_c_base;
    logic [c_row_w-1:0]      r_issue_cnt, r_xfer_cnt, r_res_cnt, r_skip_cnt, r_idle_cnt;
    logic                    r_wload_en;
    logic [c_col_w-1:0]      r_wload_col;
    logic                    r_ab_rvld;
    logic                    r_error;

    logic w_accept, w_xfer, w_collect, w_skip, w_cb_write, w_res_last, w_timeout;
    logic w_skid_flush, w_skid_in_valid;

    assign w_accept   = (r_state == IDLE) && cmd_valid;
    assign w_xfer     = sa_act_valid && sa_act_ready;
    assign w_collect  = ((r_state == STREAM) || (r_state == DRAIN)) && sa_result_valid;
    assign w_skip     = r_skip_cnt < c_row_w'(RESULT_SKIP);
    assign w_cb_write = w_collect && !w_skip;
    assign w_res_last = w_cb_write && (r_res_cnt == r_m_rows - c_row_w'(1));

    assign cmd_ready           = (r_state == IDLE);
    assign busy                = (r_state != IDLE);
    assign done                = (r_state == DONE);
    assign sa_start            = (r_state == START);
    assign sa_clear_acc        = (r_state == START);
    assign sa_cfg_k_tiles      = 16'(ARRAY_SIZE);
    assign sa_result_ready     = 1'b1;
    assign error               = r_error;
    assign wb_rd_addr          = r_w_base + ADDR_WIDTH'(r_issue_cnt);
    assign ab_rd_addr          = r_a_base + ADDR_WIDTH'(r_issue_cnt);
    assign cb_wr_en            = w_cb_write;
    assign cb_wr_addr          = r_c_base + ADDR_WIDTH'(r_res_cnt);
    assign cb_wr_data          = w_cb_write ? sa_result_data : '0;
    assign sa_weight_load_en   = r_wload_en;
    assign sa_weight_load_col  = r_wload_col;
    assign sa_weight_load_data = r_wload_en ? wb_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        wb_rd_en  = 1'b0;
        ab_rd_en  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) w_next = (cmd_m_rows == 16'd0) ? DONE : LOAD_W;
            end
            LOAD_W: begin
                wb_rd_en = r_issue_cnt < c_row_w'(ARRAY_SIZE);
                if (r_wload_en && (r_wload_col == c_col_w'(ARRAY_SIZE - 1))) w_next = START;
            end
            START: w_next = STREAM;
            STREAM: begin
                // A refused row blocks further reads so nothing is dropped or duplicated.
                ab_rd_en = (r_issue_cnt < r_m_rows) && (!sa_act_valid || sa_act_ready);
                if (w_res_last)
                    w_next = DONE;
                else if (w_xfer && (r_xfer_cnt == r_m_rows - c_row_w'(1)))
                    w_next = DRAIN;
            end
            DRAIN: begin
                if (w_res_last) begin
                    w_next = DONE;
                end else if (!sa_result_valid && (r_idle_cnt == c_row_w'(DRAIN_TIMEOUT - 1))) begin
                    w_next    = DONE;
                    w_timeout = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_rows    <= '0;
            r_w_base    <= '0;
            r_a_base    <= '0;
            r_c_base    <= '0;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
            r_res_cnt   <= '0;
            r_skip_cnt  <= '0;
            r_idle_cnt  <= '0;
            r_wload_en  <= 1'b0;
            r_wload_col <= '0;
            r_ab_rvld   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_rows    <= cmd_m_rows;
                r_w_base    <= cmd_w_base;
                r_a_base    <= cmd_a_base;
                r_c_base    <= cmd_c_base;
                r_issue_cnt <= '0;
                r_xfer_cnt  <= '0;
                r_res_cnt   <= '0;
                r_skip_cnt  <= '0;
                r_idle_cnt  <= '0;
                r_error     <= 1'b0;
            end else begin
                // The read counter is shared by the weight and activation phases.
                if (wb_rd_en || ab_rd_en)  r_issue_cnt <= r_issue_cnt + c_row_w'(1);
                else if (r_state == START) r_issue_cnt <= '0;
                if (w_xfer) r_xfer_cnt <= r_xfer_cnt + c_row_w'(1);
                if (w_collect) begin
                    if (w_skip) r_skip_cnt <= r_skip_cnt + c_row_w'(1);
                    else        r_res_cnt  <= r_res_cnt + c_row_w'(1);
                end
                if ((r_state == DRAIN) && !sa_result_valid) r_idle_cnt <= r_idle_cnt + c_row_w'(1);
                else                                        r_idle_cnt <= '0;
                if (w_timeout) r_error <= 1'b1;
            end
            r_wload_en  <= wb_rd_en;
            r_wload_col <= c_col_w'(r_issue_cnt);
            r_ab_rvld   <= ab_rd_en;
        end
    end

    assign w_skid_flush    = (r_state != STREAM);
    assign w_skid_in_valid = r_ab_rvld && (r_state == STREAM);

    seq_skid_reg #(
        .WIDTH (c_vec_w)
    ) u_act_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (w_skid_flush),
        .in_valid  (w_skid_in_valid),
        .in_data   (ab_rd_data),
        .out_valid (sa_act_valid),
        .out_data  (sa_act_data),
        .out_ready (sa_act_ready)
    );

endmodule
`default_nettype wire

// File: tb/tb_gemm_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_tile_sequencer
// Brief    : Directed bench with buffer and array models for gemm_tile_sequencer
// Revision : 1.0
// ============================================================================
module tb_gemm_tile_sequencer;

    localparam logic [127:0] C_DUMMY = 128'h0000_DEAD_0000_DEAD_0000_DEAD_0000_DEAD;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid, cmd_ready;
    logic [15:0]  cmd_m_rows;
    logic [9:0]   cmd_w_base, cmd_a_base, cmd_c_base;
    logic         wb_rd_en, ab_rd_en, cb_wr_en;
    logic [9:0]   wb_rd_addr, ab_rd_addr, cb_wr_addr;
    logic [31:0]  wb_rd_data, ab_rd_data;
    logic [127:0] cb_wr_data;
    logic         sa_start, sa_clear_acc;
    logic [15:0]  sa_cfg_k_tiles;
    logic         sa_weight_load_en;
    logic [1:0]   sa_weight_load_col;
    logic [31:0]  sa_weight_load_data;
    logic         sa_act_valid, sa_act_ready;
    logic [31:0]  sa_act_data;
    logic         sa_result_valid, sa_result_ready;
    logic [127:0] sa_result_data;
    logic         busy, done, error;

    gemm_tile_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_m_rows(cmd_m_rows),
        .cmd_w_base(cmd_w_base), .cmd_a_base(cmd_a_base), .cmd_c_base(cmd_c_base),
        .wb_rd_en(wb_rd_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ab_rd_en(ab_rd_en), .ab_rd_addr(ab_rd_addr), .ab_rd_data(ab_rd_data),
        .cb_wr_en(cb_wr_en), .cb_wr_addr(cb_wr_addr), .cb_wr_data(cb_wr_data),
        .sa_start(sa_start), .sa_clear_acc(sa_clear_acc), .sa_cfg_k_tiles(sa_cfg_k_tiles),
        .sa_weight_load_en(sa_weight_load_en), .sa_weight_load_col(sa_weight_load_col),
        .sa_weight_load_data(sa_weight_load_data),
        .sa_act_valid(sa_act_valid), .sa_act_data(sa_act_data), .sa_act_ready(sa_act_ready),
        .sa_result_valid(sa_result_valid), .sa_result_data(sa_result_data),
        .sa_result_ready(sa_result_ready),
        .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  wmem [0:1023];
    logic [31:0]  amem [0:1023];
    logic [127:0] exp_rows [0:3];
    logic [31:0]  wcol [0:3];
    logic [127:0] rq [$];
    logic [9:0]   wlog_addr [$];
    logic [127:0] wlog_data [$];

    int n_cmp, n_fail;
    int cyc, t_acc, t_done;
    int n_wb, n_ab, n_cb, n_start, n_xfer, n_stallc, n_done;
    logic err_done;
    int n_emit, emit_max;
    int stall_cycles, x_base, s_base;

    // Buffers with one-cycle read latency.
    always @(posedge clk) begin
        if (wb_rd_en) wb_rd_data <= wmem[wb_rd_addr];
        if (ab_rd_en) ab_rd_data <= amem[ab_rd_addr];
    end

    function automatic logic [127:0] mac(input logic [31:0] act);
        logic [127:0] r;
        logic [31:0]  s;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            s = 32'd0;
            for (int i = 0; i < 4; i++)
                s = s + 32'(act[i*8 +: 8]) * 32'(wcol[j][i*8 +: 8]);
            r[j*32 +: 32] = s;
        end
        return r;
    endfunction

    // Array model: one leading pipeline beat after start, then one result per act row.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq.delete();
            sa_result_valid <= 1'b0;
            sa_result_data  <= '0;
            n_emit          <= 0;
        end else begin
            if (sa_weight_load_en) wcol[sa_weight_load_col] <= sa_weight_load_data;
            if (sa_start) begin
                rq.delete();
                rq.push_back(C_DUMMY);
            end
            if (sa_act_valid && sa_act_ready) rq.push_back(mac(sa_act_data));
            if ((rq.size() != 0) && ((sa_start ? 0 : n_emit) < emit_max)) begin
                sa_result_data  <= rq.pop_front();
                sa_result_valid <= 1'b1;
                n_emit          <= (sa_start ? 0 : n_emit) + 1;
            end else begin
                sa_result_valid <= 1'b0;
                if (sa_start) n_emit <= 0;
            end
        end
    end

    always @(negedge clk)
        sa_act_ready <= !(sa_act_valid && ((n_xfer - x_base) == 1) && ((n_stallc - s_base) < stall_cycles));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) t_acc <= cyc;
        if (done) begin
            t_done   <= cyc;
            err_done <= error;
            n_done   <= n_done + 1;
        end
        if (wb_rd_en) n_wb <= n_wb + 1;
        if (ab_rd_en) n_ab <= n_ab + 1;
        if (sa_start && sa_clear_acc) n_start <= n_start + 1;
        if (sa_act_valid && sa_act_ready) n_xfer <= n_xfer + 1;
        if (sa_act_valid && !sa_act_ready) n_stallc <= n_stallc + 1;
        if (cb_wr_en) begin
            n_cb <= n_cb + 1;
            wlog_addr.push_back(cb_wr_addr);
            wlog_data.push_back(cb_wr_data);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] m, input logic [9:0] cb);
        @(negedge clk);
        cmd_m_rows = m;
        cmd_w_base = 10'd16;
        cmd_a_base = 10'd32;
        cmd_c_base = cb;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic run_cmd(input string tag, input logic [15:0] m, input logic [9:0] cb,
                           input int stall, input int exp_lat, input int exp_wr, input logic exp_err);
        int b_wb, b_ab, b_cb, b_st, b_x, b_sc, b_done, b_log, i;
        int e_rd;
        b_wb = n_wb; b_ab = n_ab; b_cb = n_cb; b_st = n_start;
        b_x = n_xfer; b_sc = n_stallc; b_done = n_done; b_log = wlog_addr.size();
        stall_cycles = stall; x_base = n_xfer; s_base = n_stallc;
        issue(m, cb);
        for (i = 0; (i < 300) && (n_done == b_done); i++) @(negedge clk);
        chk({tag, "_done_seen"}, 128'(n_done - b_done), 128'(1));
        chk({tag, "_latency"}, 128'(t_done - t_acc), 128'(exp_lat));
        chk({tag, "_err_at_done"}, 128'(err_done), 128'(exp_err));
        chk({tag, "_done_1cyc"}, 128'(done), 128'(0));
        chk({tag, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
        chk({tag, "_n_cb"}, 128'(n_cb - b_cb), 128'(exp_wr));
        for (int k = 0; k < exp_wr; k++) begin
            if (b_log + k < wlog_addr.size()) begin
                chk({tag, "_cb_addr"}, 128'(wlog_addr[b_log + k]), 128'(10'(cb + 10'(k))));
                chk({tag, "_cb_data"}, wlog_data[b_log + k], exp_rows[k]);
            end else begin
                chk({tag, "_cb_missing"}, 128'(0), 128'(1));
            end
        end
        e_rd = (m == 16'd0) ? 0 : 4;
        chk({tag, "_n_wb"}, 128'(n_wb - b_wb), 128'(e_rd));
        chk({tag, "_n_start"}, 128'(n_start - b_st), 128'((m == 16'd0) ? 0 : 1));
        chk({tag, "_n_ab"}, 128'(n_ab - b_ab), 128'(m));
        chk({tag, "_n_xfer"}, 128'(n_xfer - b_x), 128'(m));
        chk({tag, "_n_stall"}, 128'(n_stallc - b_sc), 128'(stall));
    endtask

    initial begin
        int b_x, b_wb, b_ab, b_cb, i;
        n_cmp = 0; n_fail = 0;
        cyc = 0; t_acc = 0; t_done = 0; err_done = 1'b0;
        n_wb = 0; n_ab = 0; n_cb = 0; n_start = 0; n_xfer = 0; n_stallc = 0; n_done = 0;
        emit_max = 1000; stall_cycles = 0; x_base = 0; s_base = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_m_rows = '0;
        cmd_w_base = '0; cmd_a_base = '0; cmd_c_base = '0;
        for (int a = 0; a < 1024; a++) begin
            wmem[a] = 32'd0;
            amem[a] = 32'd0;
        end
        wmem[16] = 32'h0000_0001;
        wmem[17] = 32'h0000_0100;
        amem[32] = 32'h0000_0201;
        amem[33] = 32'h0000_0403;
        exp_rows[0] = {32'd0, 32'd0, 32'd2, 32'd1};
        exp_rows[1] = {32'd0, 32'd0, 32'd4, 32'd3};
        exp_rows[2] = '0;
        exp_rows[3] = '0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_res_ready", 128'(sa_result_ready), 128'(1));
        chk("rst_k_tiles", 128'(sa_cfg_k_tiles), 128'(4));
        chk("rst_ctrl", 128'({done, error, wb_rd_en, ab_rd_en, cb_wr_en, sa_start,
                              sa_clear_acc, sa_weight_load_en, sa_act_valid}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("basic", 16'd4, 10'd64, 0, 13, 4, 1'b0);
        run_cmd("stall", 16'd4, 10'd64, 3, 16, 4, 1'b0);
        run_cmd("m0", 16'd0, 10'd64, 0, 1, 0, 1'b0);

        emit_max = 2;
        run_cmd("timeout", 16'd4, 10'd64, 0, 76, 1, 1'b1);
        @(negedge clk);
        chk("err_sticky", 128'(error), 128'(1));
        emit_max = 1000;
        run_cmd("err_clear", 16'd0, 10'd64, 0, 1, 0, 1'b0);

        run_cmd("wrap", 16'd2, 10'h3FF, 0, 11, 2, 1'b0);

        // Asynchronous reset while streaming.
        b_x = n_xfer;
        issue(16'd4, 10'd64);
        for (i = 0; (i < 50) && (n_xfer == b_x); i++) @(negedge clk);
        chk("rst_mid_streaming", 128'(n_xfer != b_x), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_cmd_ready", 128'(cmd_ready), 128'(1));
        chk("rst_mid_ctrl", 128'({busy, ab_rd_en, sa_act_valid, cb_wr_en, wb_rd_en, done}), 128'(0));
        b_wb = n_wb; b_ab = n_ab; b_cb = n_cb;
        repeat (3) @(negedge clk);
        chk("rst_mid_quiet", 128'((n_wb - b_wb) + (n_ab - b_ab) + (n_cb - b_cb)), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_cmd_ready", 128'(cmd_ready), 128'(1));
        run_cmd("post_rst", 16'd4, 10'd64, 0, 13, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
